// File: rtl/div_datapath.sv
// div_datapath: register datapath of an 8-bit by 7-bit unsigned
// shift/subtract divider. An external controller sequences it with
// load/shift/add commands and reads sign to decide each quotient bit.
module div_datapath (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       shift,
    input  logic       add,
    input  logic       inbit,
    input  logic [1:0] sel,
    input  logic [6:0] divisorin,
    input  logic [7:0] dividendin,
    output logic [6:0] remainder,
    output logic [7:0] quotient,
    output logic       sign
);

    // Accumulator operations selected by sel while add is active
    typedef enum logic [1:0] {
        OP_ADD    = 2'b00,
        OP_SUB    = 2'b01,
        OP_SETBIT = 2'b10,
        OP_CLEAR  = 2'b11
    } add_op_t;

    // Divisor, 9-bit signed partial remainder, dividend/quotient shift register
    logic [6:0] d_reg;
    logic [8:0] a_reg;
    logic [7:0] q_reg;

    // Divisor zero-extended to accumulator width for add/subtract
    logic [8:0] d_ext;
    assign d_ext = {2'b00, d_reg};

    add_op_t add_op;
    assign add_op = add_op_t'(sel);

    // Register update; only the highest-priority command acts on each edge
    always_ff @(posedge clk) begin
        if (!reset) begin
            d_reg <= 7'd0;
            a_reg <= 9'd0;
            q_reg <= 8'd0;
        end else if (load) begin
            d_reg <= divisorin;
            a_reg <= 9'd0;
            q_reg <= dividendin;
        end else if (shift) begin
            a_reg <= {a_reg[7:0], q_reg[7]};
            q_reg <= {q_reg[6:0], inbit};
        end else if (add) begin
            case (add_op)
                OP_ADD:    a_reg <= a_reg + d_ext;
                OP_SUB:    a_reg <= a_reg - d_ext;
                OP_SETBIT: q_reg[0] <= inbit;
                OP_CLEAR:  a_reg <= 9'd0;
                default:   a_reg <= a_reg;
            endcase
        end
    end

    assign remainder = a_reg[6:0];
    assign quotient  = q_reg;
    assign sign      = a_reg[8];

endmodule

// File: tb/tb_div_datapath.sv
// tb_div_datapath: directed self-checking bench for the divider datapath,
// including full restoring divisions driven by a small controller sequence.
module tb_div_datapath;

    logic       clk;
    logic       reset;
    logic       load;
    logic       shift;
    logic       add;
    logic       inbit;
    logic [1:0] sel;
    logic [6:0] divisorin;
    logic [7:0] dividendin;
    logic [6:0] remainder;
    logic [7:0] quotient;
    logic       sign;

    int checks = 0;
    int errors = 0;

    div_datapath dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .shift      (shift),
        .add        (add),
        .inbit      (inbit),
        .sel        (sel),
        .divisorin  (divisorin),
        .dividendin (dividendin),
        .remainder  (remainder),
        .quotient   (quotient),
        .sign       (sign)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value with its expected value
    task automatic checkOutput(input string tag, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Drive one command for a single edge, then return to idle
    task automatic applyStimulus(input logic rst_n, input logic ld, input logic sh,
                                 input logic ad, input logic [1:0] s, input logic ib);
        reset = rst_n;
        load  = ld;
        shift = sh;
        add   = ad;
        sel   = s;
        inbit = ib;
        @(posedge clk);
        #1;
        reset = 1'b1;
        load  = 1'b0;
        shift = 1'b0;
        add   = 1'b0;
        sel   = 2'b00;
        inbit = 1'b0;
    endtask

    task automatic checkAll(input string tag, input logic [7:0] exp_q,
                            input logic [6:0] exp_r, input logic exp_s);
        checkOutput({tag, ".quotient"},  16'(quotient),  16'(exp_q));
        checkOutput({tag, ".remainder"}, 16'(remainder), 16'(exp_r));
        checkOutput({tag, ".sign"},      16'(sign),      16'(exp_s));
    endtask

    // Restoring division driven as the controller would
    task automatic runDivide(input logic [7:0] dividend, input logic [6:0] divisor,
                             input logic [7:0] exp_q, input logic [6:0] exp_r,
                             input string tag);
        divisorin  = divisor;
        dividendin = dividend;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
            if (sign)
                applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
            else
                applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1);
        end
        checkAll(tag, exp_q, exp_r, 1'b0);
    endtask

    // Directed test sequence
    initial begin
        reset      = 1'b1;
        load       = 1'b0;
        shift      = 1'b0;
        add        = 1'b0;
        sel        = 2'b00;
        inbit      = 1'b0;
        divisorin  = 7'd0;
        dividendin = 8'd0;
        #2;

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        checkAll("reset", 8'h00, 7'h00, 1'b0);

        divisorin  = 7'd5;
        dividendin = 8'hC8;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        checkAll("load", 8'hC8, 7'h00, 1'b0);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        checkAll("idle_hold", 8'hC8, 7'h00, 1'b0);

        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1);
        checkAll("shift", 8'h91, 7'h01, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
        checkAll("sub_neg", 8'h91, 7'h7C, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
        checkAll("restore", 8'h91, 7'h01, 1'b0);

        runDivide(8'd200, 7'd5,   8'd40,  7'd0, "div200_5");
        runDivide(8'd200, 7'd7,   8'd28,  7'd4, "div200_7");
        runDivide(8'd255, 7'd1,   8'd255, 7'd0, "div255_1");
        runDivide(8'd3,   7'd127, 8'd0,   7'd3, "div3_127");
        runDivide(8'hAB,  7'd0,   8'hFF,  7'h2B, "div_by_zero");

        divisorin  = 7'd9;
        dividendin = 8'h3C;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 1'b1);
        checkAll("prio_load", 8'h3C, 7'h00, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
        checkAll("prio_load_d", 8'h3C, 7'd9, 1'b0);

        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        checkAll("prio_reset", 8'h00, 7'h00, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
        checkAll("reset_clears_d", 8'h00, 7'h00, 1'b0);

        divisorin  = 7'd3;
        dividendin = 8'h5A;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
        checkAll("add_d", 8'h5A, 7'd3, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0);
        checkAll("clear_a", 8'h5A, 7'h00, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1);
        checkAll("set_q0", 8'h5B, 7'h00, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0);
        checkAll("prio_shift", 8'hB6, 7'h00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
